// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter sharing the regfile write port between two writeback requesters
// Optional WB_SCOREBOARD_EN builds the pend_mask in-flight register decode.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic                 isWa,
  output logic [ADDR_W-1:0]    wa,
  output logic [DATA_W-1:0]    wd,
  output logic [2**ADDR_W-1:0] pend_mask,
  output logic [CNT_W-1:0]     conflict_cnt
);

  logic [1:0]        hold_v;
  logic [ADDR_W-1:0] hold0_addr, hold1_addr;
  logic [DATA_W-1:0] hold0_data, hold1_data;
  logic              age;  // 1: hold1 is the older entry
  logic              rr;   // 1: hold1 wins the next contended diff-addr grant
  logic [1:0]        grant;
  logic              acc0, acc1;

  always_comb begin
    grant = 2'b00;
    case (hold_v)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (hold0_addr == hold1_addr) grant = age ? 2'b10 : 2'b01;
        else                          grant = rr  ? 2'b10 : 2'b01;
      end
      default: grant = 2'b00;
    endcase
  end

  assign req0_ready = !Reset && (!hold_v[0] || grant[0]);
  assign req1_ready = !Reset && (!hold_v[1] || grant[1]);
  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;

  always_ff @(posedge clk) begin
    if (Reset) begin
      hold_v       <= 2'b00;
      age          <= 1'b0;
      rr           <= 1'b0;
      isWa         <= 1'b0;
      wa           <= '0;
      wd           <= '0;
      conflict_cnt <= '0;
    end else begin
      if (|grant) begin
        isWa <= 1'b1;
        wa   <= grant[1] ? hold1_addr : hold0_addr;
        wd   <= grant[1] ? hold1_data : hold0_data;
      end else begin
        isWa <= 1'b0;
      end

      if (hold_v == 2'b11) begin
        rr <= grant[0];
        if (conflict_cnt != {CNT_W{1'b1}})
          conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      hold_v[0] <= acc0 || (hold_v[0] && !grant[0]);
      hold_v[1] <= acc1 || (hold_v[1] && !grant[1]);
      if (acc0) begin
        hold0_addr <= req0_addr;
        hold0_data <= req0_data;
      end
      if (acc1) begin
        hold1_addr <= req1_addr;
        hold1_data <= req1_data;
      end

      // A new entry is younger than a surviving entry in the other hold.
      if (acc0 && acc1)                        age <= 1'b0;
      else if (acc0 && hold_v[1] && !grant[1]) age <= 1'b1;
      else if (acc1 && hold_v[0] && !grant[0]) age <= 1'b0;
    end
  end

`ifdef WB_SCOREBOARD_EN
  always_comb begin
    pend_mask = '0;
    if (hold_v[0]) pend_mask[hold0_addr] = 1'b1;
    if (hold_v[1]) pend_mask[hold1_addr] = 1'b1;
    if (isWa)      pend_mask[wa]         = 1'b1;
  end
`else
  assign pend_mask = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               Reset = 1'b1;
  logic               req0_valid = 1'b0, req1_valid = 1'b0;
  logic [ADDR_W-1:0]  req0_addr = '0, req1_addr = '0;
  logic [DATA_W-1:0]  req0_data = '0, req1_data = '0;
  logic               req0_ready, req1_ready, isWa;
  logic [ADDR_W-1:0]  wa;
  logic [DATA_W-1:0]  wd;
  logic [15:0]        pend_mask;
  logic [CNT_W-1:0]   conflict_cnt;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .isWa(isWa), .wa(wa), .wd(wd), .pend_mask(pend_mask), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each hold is a slot stamped with its acceptance time.
  bit          m_v[2];
  logic [3:0]  m_a[2];
  logic [31:0] m_d[2];
  int          m_t[2];
  int          m_rr, m_stamp, m_cnt, m_g;
  bit          m_we, m_rdy0, m_rdy1;
  logic [3:0]  m_wa;
  logic [31:0] m_wd;
  bit          cur_r, cur_v0, cur_v1;
  logic [3:0]  cur_a0, cur_a1;
  logic [31:0] cur_d0, cur_d1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v[0] = 0; m_v[1] = 0; m_t[0] = 0; m_t[1] = 0;
    m_rr = 0; m_stamp = 0; m_cnt = 0; m_we = 0; m_wa = '0; m_wd = '0;
  endtask

  function automatic int model_gsel();
    if (m_v[0] && m_v[1]) begin
      if (m_a[0] == m_a[1]) return (m_t[0] < m_t[1]) ? 0 : 1;
      return m_rr;
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  function automatic logic [15:0] model_pend();
    logic [15:0] p = '0;
`ifdef WB_SCOREBOARD_EN
    if (m_v[0]) p[m_a[0]] = 1'b1;
    if (m_v[1]) p[m_a[1]] = 1'b1;
    if (m_we)   p[m_wa]   = 1'b1;
`endif
    return p;
  endfunction

  task automatic drive(input bit r, input bit v0, input logic [3:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [3:0] a1, input logic [31:0] d1);
    @(negedge clk);
    Reset = r; req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    cur_r = r; cur_v0 = v0; cur_a0 = a0; cur_d0 = d0; cur_v1 = v1; cur_a1 = a1; cur_d1 = d1;
    #1;
    m_g = model_gsel();
    m_rdy0 = !r && (!m_v[0] || m_g == 0);
    m_rdy1 = !r && (!m_v[1] || m_g == 1);
    check("ready0", req0_ready, m_rdy0);
    check("ready1", req1_ready, m_rdy1);
    check("isWa", isWa, m_we);
    check("wa", wa, m_wa);
    check("wd", wd, m_wd);
    check("conflict_cnt", conflict_cnt, m_cnt);
    check("pend_mask", pend_mask, model_pend());
  endtask

  task automatic clock_edge();
    bit acc0, acc1;
    @(posedge clk);
    acc0 = cur_v0 && m_rdy0;
    acc1 = cur_v1 && m_rdy1;
    if (cur_r) begin
      model_reset();
    end else begin
      if (m_v[0] && m_v[1] && m_cnt < CNT_MAX) m_cnt++;
      if (m_g >= 0) begin
        m_we = 1; m_wa = m_a[m_g]; m_wd = m_d[m_g];
        if (m_v[0] && m_v[1]) m_rr = 1 - m_g;
        m_v[m_g] = 0;
      end else begin
        m_we = 0;
      end
      if (acc0) begin m_v[0] = 1; m_a[0] = cur_a0; m_d[0] = cur_d0; m_t[0] = m_stamp * 2; end
      if (acc1) begin m_v[1] = 1; m_a[1] = cur_a1; m_d[1] = cur_d1; m_t[1] = m_stamp * 2 + 1; end
      if (acc0 || acc1) m_stamp++;
    end
  endtask

  task automatic cyc(input bit r, input bit v0, input logic [3:0] a0, input logic [31:0] d0,
                     input bit v1, input logic [3:0] a1, input logic [31:0] d1);
    drive(r, v0, a0, d0, v1, a1, d1);
    clock_edge();
  endtask

  typedef struct {
    bit          rst;
    bit          v0; logic [3:0] a0; logic [31:0] d0;
    bit          v1; logic [3:0] a1; logic [31:0] d1;
    bit          r0, r1, we;
    logic [3:0]  wa;
    logic [31:0] wd;
    int          cnt;
  } vec_t;

  vec_t tbl[28];
  logic [15:0] pend9;

  initial begin
    // reset hold, single write, contention, same-register order, age versus rr
    tbl[0]  = '{1, 1,1,32'h1, 1,2,32'h2,  0,0,0, 0,32'h0, 0};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{0, 0,0,0, 0,0,0,          1,1,0, 0,32'h0, 0};
    tbl[4]  = '{0, 1,3,32'hA5A50001, 0,0,0, 1,1,0, 0,32'h0, 0};
    tbl[5]  = '{0, 0,0,0, 0,0,0,          1,1,0, 0,32'h0, 0};
    tbl[6]  = '{0, 0,0,0, 0,0,0,          1,1,1, 3,32'hA5A50001, 0};
    tbl[7]  = '{0, 0,0,0, 0,0,0,          1,1,0, 3,32'hA5A50001, 0};
    tbl[8]  = '{0, 1,4,32'h40, 1,7,32'h70, 1,1,0, 3,32'hA5A50001, 0};
    tbl[9]  = '{0, 1,4,32'h40, 1,7,32'h70, 1,0,0, 3,32'hA5A50001, 0};
    tbl[10] = '{0, 1,4,32'h40, 1,7,32'h70, 0,1,1, 4,32'h40, 1};
    tbl[11] = '{0, 1,4,32'h40, 1,7,32'h70, 1,0,1, 7,32'h70, 2};
    tbl[12] = '{0, 0,0,0, 0,0,0,          0,1,1, 4,32'h40, 3};
    tbl[13] = '{0, 0,0,0, 0,0,0,          1,1,1, 7,32'h70, 4};
    tbl[14] = '{0, 0,0,0, 0,0,0,          1,1,1, 4,32'h40, 4};
    tbl[15] = '{0, 0,0,0, 0,0,0,          1,1,0, 4,32'h40, 4};
    tbl[16] = '{0, 0,0,0, 1,5,32'h11,     1,1,0, 4,32'h40, 4};
    tbl[17] = '{0, 1,5,32'h22, 0,0,0,     1,1,0, 4,32'h40, 4};
    tbl[18] = '{0, 0,0,0, 0,0,0,          1,1,1, 5,32'h11, 4};
    tbl[19] = '{0, 0,0,0, 0,0,0,          1,1,1, 5,32'h22, 4};
    tbl[20] = '{0, 0,0,0, 0,0,0,          1,1,0, 5,32'h22, 4};
    tbl[21] = '{0, 1,6,32'h60, 1,8,32'h80, 1,1,0, 5,32'h22, 4};
    tbl[22] = '{0, 0,0,0, 0,0,0,          1,0,0, 5,32'h22, 4};
    tbl[23] = '{0, 1,9,32'h90, 1,9,32'h91, 1,1,1, 6,32'h60, 5};
    tbl[24] = '{0, 0,0,0, 0,0,0,          1,0,1, 8,32'h80, 5};
    tbl[25] = '{0, 0,0,0, 0,0,0,          1,1,1, 9,32'h90, 6};
    tbl[26] = '{0, 0,0,0, 0,0,0,          1,1,1, 9,32'h91, 6};
    tbl[27] = '{0, 0,0,0, 0,0,0,          1,1,0, 9,32'h91, 6};

    repeat (2) @(posedge clk);
    model_reset();

    for (int k = 0; k < 28; k++) begin
      drive(tbl[k].rst, tbl[k].v0, tbl[k].a0, tbl[k].d0, tbl[k].v1, tbl[k].a1, tbl[k].d1);
      check($sformatf("tbl%0d_ready0", k), req0_ready, tbl[k].r0);
      check($sformatf("tbl%0d_ready1", k), req1_ready, tbl[k].r1);
      check($sformatf("tbl%0d_isWa", k), isWa, tbl[k].we);
      check($sformatf("tbl%0d_wa", k), wa, tbl[k].wa);
      check($sformatf("tbl%0d_wd", k), wd, tbl[k].wd);
      check($sformatf("tbl%0d_cnt", k), conflict_cnt, tbl[k].cnt);
      clock_edge();
    end

    // Reset while both holds are full: nothing may reach the regfile afterwards.
    cyc(0, 1, 1, 32'hAA, 1, 2, 32'hBB);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      check("rst_midop_isWa", isWa, 1'b0);
      check("rst_midop_ready0", req0_ready, 1'b1);
      check("rst_midop_ready1", req1_ready, 1'b1);
      clock_edge();
    end

    // In-flight register 9 shows in pend_mask through hold and output stages.
`ifdef WB_SCOREBOARD_EN
    pend9 = 16'h0200;
`else
    pend9 = 16'h0000;
`endif
    cyc(0, 1, 9, 32'h99, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("pend_hold", pend_mask, pend9);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("pend_isWa", pend_mask, pend9);
    check("pend_isWa_we", isWa, 1'b1);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("pend_clear", pend_mask, 16'h0);
    check("pend_clear_we", isWa, 1'b0);
    clock_edge();

    // Sustained contention saturates the counter.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, i, 1, 2, i + 100);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("cnt_saturate", conflict_cnt, CNT_MAX);
    clock_edge();
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);

    // Randomised traffic with occasional resets, narrow address range for collisions.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 3)), $urandom,
          ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 3)), $urandom);
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
